// File: rtl/riscv_div_unit.sv
// Iterative radix-2 restoring divider for the M-extension DIV/DIVU/REM/REMU ops.
// Divide-by-zero and signed overflow resolve at issue; normal ops take WIDTH busy cycles.
module riscv_div_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned OP_WIDTH = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [OP_WIDTH-1:0] op_i,
    input  logic [WIDTH-1:0]    operand_a_i,
    input  logic [WIDTH-1:0]    operand_b_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [WIDTH-1:0]    result_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [OP_WIDTH-3:0] DIV_BASE = (OP_WIDTH-2)'(5'b01100);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state, state_next;
    logic [CNT_W-1:0]  counter;
    logic              is_rem_q, neg_q_q, neg_r_q;
    logic [WIDTH-1:0]  dividend_q;
    logic [WIDTH-1:0]  divisor_q;
    logic [WIDTH-1:0]  rem_q;

    logic              accept_c, legal_c, is_signed_c, is_rem_c;
    logic              div_zero_c, overflow_c, fast_c;
    logic              a_neg_c, b_neg_c;
    logic [WIDTH-1:0]  a_mag_c, b_mag_c, fast_result_c;
    logic [WIDTH:0]    rem_shift_c, trial_c;
    logic [WIDTH-1:0]  rem_next_c, quo_next_c, final_result_c;

    // Issue decode and one-cycle resolution of special cases
    always_comb begin
        legal_c       = (op_i[OP_WIDTH-1:2] == DIV_BASE);
        is_signed_c   = op_i[0];
        is_rem_c      = op_i[1];
        a_neg_c       = is_signed_c & operand_a_i[WIDTH-1];
        b_neg_c       = is_signed_c & operand_b_i[WIDTH-1];
        a_mag_c       = a_neg_c ? (~operand_a_i + WIDTH'(1)) : operand_a_i;
        b_mag_c       = b_neg_c ? (~operand_b_i + WIDTH'(1)) : operand_b_i;
        div_zero_c    = (operand_b_i == '0);
        overflow_c    = is_signed_c && (operand_a_i == MIN_NEG) && (operand_b_i == '1);
        fast_c        = !legal_c || div_zero_c || overflow_c;
        fast_result_c = '0;
        if (!legal_c) begin
            fast_result_c = '0;
        end else if (div_zero_c) begin
            fast_result_c = is_rem_c ? operand_a_i : '1;
        end else if (overflow_c) begin
            fast_result_c = is_rem_c ? '0 : MIN_NEG;
        end
    end

    // One restoring step: shift in the next dividend bit and trial-subtract
    always_comb begin
        rem_shift_c = {rem_q, dividend_q[WIDTH-1]};
        trial_c     = rem_shift_c - {1'b0, divisor_q};
        rem_next_c  = trial_c[WIDTH] ? rem_shift_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
        quo_next_c  = {dividend_q[WIDTH-2:0], ~trial_c[WIDTH]};
        if (is_rem_q) begin
            final_result_c = neg_r_q ? (~rem_next_c + WIDTH'(1)) : rem_next_c;
        end else begin
            final_result_c = neg_q_q ? (~quo_next_c + WIDTH'(1)) : quo_next_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; flush overrides every transition
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    accept_c   = 1'b1;
                    state_next = fast_c ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (counter == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
            accept_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            result_o   <= '0;
            counter    <= '0;
            is_rem_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
        end else begin
            ready_o <= (state_next == IDLE);
            valid_o <= (state_next == DONE);
            if (flush_i) begin
                counter <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        counter <= '0;
                        if (accept_c) begin
                            is_rem_q   <= is_rem_c;
                            neg_q_q    <= a_neg_c ^ b_neg_c;
                            neg_r_q    <= a_neg_c;
                            dividend_q <= a_mag_c;
                            divisor_q  <= b_mag_c;
                            rem_q      <= '0;
                            if (fast_c) begin
                                result_o <= fast_result_c;
                            end
                        end
                    end
                    BUSY: begin
                        rem_q      <= rem_next_c;
                        dividend_q <= quo_next_c;
                        if (counter == LAST_CNT) begin
                            counter  <= '0;
                            result_o <= final_result_c;
                        end else begin
                            counter <= counter + CNT_W'(1);
                        end
                    end
                    default: counter <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_div_unit.sv
// Scoreboard bench for riscv_div_unit: directed cases, special cases, backpressure,
// flush, mid-operation reset and a handful of random operations.
module tb_riscv_div_unit;

    localparam logic [6:0] ALU_ADD  = 7'b0000000;
    localparam logic [6:0] ALU_DIVU = 7'b0110000;
    localparam logic [6:0] ALU_DIV  = 7'b0110001;
    localparam logic [6:0] ALU_REMU = 7'b0110010;
    localparam logic [6:0] ALU_REM  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst, flush_i, valid_i, ready_o, valid_o, ready_i;
    logic [6:0]  op_i;
    logic [31:0] operand_a_i, operand_b_i, result_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    riscv_div_unit #(.WIDTH(32), .OP_WIDTH(7)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (op[6:2] != 5'b01100) return 32'h0;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        if (op[0]) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int model_lat(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        if (model(op, a, b) != 32'h0 || 1'b1) begin
            if (op[6:2] != 5'b01100 || b == 32'h0 ||
                (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        end
        return 33;
    endfunction

    // Issue one request at a negedge, push expectations, then wait for and check the result
    task automatic run_op(input string tag, input logic [6:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int stall);
        int lat;
        logic [31:0] e;
        int el;
        @(negedge clk);
        ready_i     = (stall == 0);
        check({tag, " ready_before"}, 32'(ready_o), 32'd1);
        op_i        = op;
        operand_a_i = a;
        operand_b_i = b;
        valid_i     = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(model_lat(op, a, b));
        @(posedge clk);
        #1;
        valid_i     = 1'b0;
        op_i        = 7'($urandom);
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        lat = 1;
        @(negedge clk);
        while (!valid_o && lat < 100) begin
            check({tag, " busy_ready"}, 32'(ready_o), 32'd0);
            @(negedge clk);
            lat++;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        check({tag, " valid_seen"}, 32'(valid_o), 32'd1);
        check({tag, " result"}, result_o, e);
        check({tag, " latency"}, 32'(lat), 32'(el));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " held_result"}, result_o, e);
            check({tag, " held_valid"}, 32'(valid_o), 32'd1);
            check({tag, " held_ready"}, 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        check({tag, " valid_drop"}, 32'(valid_o), 32'd0);
        check({tag, " ready_rise"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [6:0]  rop;
        int          seen;
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        op_i = ALU_DIVU; operand_a_i = '0; operand_b_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", 32'(ready_o), 32'd1);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset result", result_o, 32'h0);
        rst = 1'b0;

        run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 0);
        run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, 0);
        run_op("div_m7_2",   ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("rem_m7_2",   ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("rem_7_m2",   ALU_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 0);
        run_op("div_5_0",    ALU_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("remu_5_0",   ALU_REMU, 32'd5, 32'd0, 32'd5, 0);
        run_op("div_ovf",    ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf",    ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
        run_op("divu_bp",    ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 5);
        run_op("rem_m8_4",   ALU_REM,  32'hFFFF_FFF8, 32'd4, 32'h0, 0);

        // Flush in the tenth busy cycle: no result, unit idle again one cycle later
        @(negedge clk);
        op_i = ALU_DIVU; operand_a_i = 32'd1000; operand_b_i = 32'd3; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (9) @(negedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush ready", 32'(ready_o), 32'd1);
        check("flush valid", 32'(valid_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        check("flush no_result", 32'(seen), 32'd0);
        run_op("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 32'd3, 0);

        // Flush together with a request in IDLE drops the request
        @(negedge clk);
        op_i = ALU_DIVU; operand_a_i = 32'd50; operand_b_i = 32'd5; valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        check("flush_drop ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        check("flush_drop valid", 32'(valid_o), 32'd0);

        // Reset while busy returns every output to its reset value
        @(negedge clk);
        op_i = ALU_DIVU; operand_a_i = 32'd77; operand_b_i = 32'd7; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst busy", 32'(ready_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst ready", 32'(ready_o), 32'd1);
        check("rst valid", 32'(valid_o), 32'd0);
        check("rst result", result_o, 32'h0);

        run_op("illegal_add", ALU_ADD, 32'd12, 32'd34, 32'h0, 0);

        for (int i = 0; i < 8; i++) begin
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            if (rb == 32'h0) rb = 32'd3;
            case (i % 4)
                0: rop = ALU_DIVU;
                1: rop = ALU_DIV;
                2: rop = ALU_REMU;
                default: rop = ALU_REM;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), i % 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
